// File: rtl/regfile_pkg.sv
// Shared sizing, state encoding and constants for the register-file write-port scheduler.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_write_sched_if.sv
// Writeback requesters, hold control and register-file write port bundled as one interface.
interface regfile_write_sched_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);
  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              write_ena;
  logic [ADDR_W-1:0] address3;
  logic [DATA_W-1:0] write_data;
  logic              init_done;

  // Scheduler side.
  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output write_ena, address3, write_data, init_done
  );

  // Writeback stage / register-file side.
  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  write_ena, address3, write_data, init_done
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  // After serving requester i the other one wins the next tie.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = ~grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: clears every register after reset, then
// arbitrates ALU and load writebacks onto the single write port.
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int                NUM_REGS     = regfile_pkg::NUM_REGS,
  parameter int                ADDR_W       = regfile_pkg::ADDR_W,
  parameter int                DATA_W       = regfile_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
  parameter bit                ZERO_PROTECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_sched_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic              write_ena_q, write_ena_d;
  logic [ADDR_W-1:0] address3_q, address3_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              init_done_q, init_done_d;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       arb_en;
  logic       advance;

  assign valid   = {bus.req1_valid, bus.req0_valid};
  assign arb_en  = (state_q == ST_RUN) && !bus.hold;
  assign advance = |(grant & valid);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .enable  (arb_en),
    .advance (advance),
    .grant   (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    write_ena_d  = 1'b0;
    address3_d   = address3_q;
    write_data_d = write_data_q;
    init_done_d  = init_done_q;

    case (state_q)
      ST_INIT: begin
        write_ena_d  = 1'b1;
        address3_d   = sweep_cnt_q;
        write_data_d = INIT_VALUE;
        sweep_cnt_d  = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        // A write to r0 is still handshaken and latched, only the enable is dropped.
        if (grant[0]) begin
          address3_d   = bus.req0_addr;
          write_data_d = bus.req0_data;
          write_ena_d  = !(ZERO_PROTECT && (bus.req0_addr == ZERO_ADDR));
        end else if (grant[1]) begin
          address3_d   = bus.req1_addr;
          write_data_d = bus.req1_data;
          write_ena_d  = !(ZERO_PROTECT && (bus.req1_addr == ZERO_ADDR));
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      sweep_cnt_q  <= '0;
      write_ena_q  <= 1'b0;
      address3_q   <= '0;
      write_data_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      write_ena_q  <= write_ena_d;
      address3_q   <= address3_d;
      write_data_q <= write_data_d;
      init_done_q  <= init_done_d;
    end
  end

  assign bus.write_ena  = write_ena_q;
  assign bus.address3   = address3_q;
  assign bus.write_data = write_data_q;
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench: stimulus queues expected writes, negedge monitors pop them as the
// write port fires. A second instance with zero protection off shares the stimulus.
module tb_regfile_write_sched;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst_n;

  regfile_write_sched_if bus ();
  regfile_write_sched_if bus_nz ();

  wr_t q0[$];
  wr_t q1[$];

  int n_vec;
  int n_err;

  regfile_write_sched #(.ZERO_PROTECT(1'b1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  regfile_write_sched #(.ZERO_PROTECT(1'b0)) dut_nz (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_nz)
  );

  assign bus_nz.hold       = bus.hold;
  assign bus_nz.req0_valid = bus.req0_valid;
  assign bus_nz.req0_addr  = bus.req0_addr;
  assign bus_nz.req0_data  = bus.req0_data;
  assign bus_nz.req1_valid = bus.req1_valid;
  assign bus_nz.req1_addr  = bus.req1_addr;
  assign bus_nz.req1_data  = bus.req1_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: every write_ena pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.write_ena === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write actual=addr %0d data %0h required=no write",
                 bus.address3, bus.write_data);
      end else begin
        wr_t e;
        e = q0.pop_front();
        chk("wr_addr", 32'(bus.address3), 32'(e.a));
        chk("wr_data", bus.write_data, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_nz.write_ena === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL nz_unexpected_write actual=addr %0d data %0h required=no write",
                 bus_nz.address3, bus_nz.write_data);
      end else begin
        wr_t e;
        e = q1.pop_front();
        chk("nz_wr_addr", 32'(bus_nz.address3), 32'(e.a));
        chk("nz_wr_data", bus_nz.write_data, e.d);
      end
    end
  end

  // Protected instance never writes r0 from a requester; the unprotected one does.
  task automatic push_req(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (a != 5'd0) q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic drive_idle();
    bus.hold       = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write_ena"},  32'(bus.write_ena),  32'd0);
    chk({tag, "_address3"},   32'(bus.address3),   32'd0);
    chk({tag, "_write_data"}, bus.write_data,      32'd0);
    chk({tag, "_init_done"},  32'(bus.init_done),  32'd0);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
  endtask

  // Runs n sweep cycles with requests pending and hold toggling; readies must stay low.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = 5'(i);
      e.d = 32'd0;
      q0.push_back(e);
      q1.push_back(e);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      bus.hold       = k[0];
      bus.req0_valid = (k < 32);
      bus.req0_addr  = 5'd9;
      bus.req0_data  = 32'h9999_9999;
      bus.req1_valid = (k < 32);
      bus.req1_addr  = 5'd10;
      bus.req1_data  = 32'hAAAA_AAAA;
      @(negedge clk);
      if (k < 32) begin
        chk("init_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("init_req1_ready", 32'(bus.req1_ready), 32'd0);
      end
      chk("init_done", 32'(bus.init_done), (k == 32) ? 32'd1 : 32'd0);
    end
    drive_idle();
  endtask

  task automatic xfer(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic h, input logic er0, input logic er1);
    @(posedge clk);
    #1;
    bus.hold       = h;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    @(negedge clk);
    chk("req0_ready", 32'(bus.req0_ready), 32'(er0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(er1));
    if (er0) push_req(a0, d0);
    else if (er1) push_req(a1, d1);
  endtask

  task automatic idle();
    xfer(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    drive_idle();
    rst_n = 1'b0;
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Interrupted sweep: reset right after address 17 is presented.
    sweep(18);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsweep_rst");
    chk("midsweep_q_empty", 32'(q0.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    sweep(32);

    // Single ALU write (pointer moves to 1).
    xfer(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle();
    // Load write to r0 (pointer moves back to 0).
    xfer(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle();
    // Both valid: alternating grants starting with req0.
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
    // Hold blocks grants for three cycles, then arbitration resumes with req0.
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    chk("run_q_empty", 32'(q0.size()), 32'd0);
    chk("run_nz_q_empty", 32'(q1.size()), 32'd0);

    // Reset during RUN restarts the full sweep.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("run_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(32);
    idle();
    idle();
    chk("end_q_empty", 32'(q0.size()), 32'd0);
    chk("end_nz_q_empty", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Write-port scheduler for the 32x32 register file.
- After reset it drives the single write port through an initialisation sweep that clears every register.
- It then shares the port between two writeback requesters (req0 = ALU writeback, req1 = load writeback) using valid/ready handshakes with round-robin arbitration.
- It sits between the writeback stage and the register file's write_ena/address3/write_data inputs.

Parameters:
- NUM_REGS, 32, number of registers swept at init.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- INIT_VALUE, 0, value written to every register during the sweep.
- ZERO_PROTECT, 1, when 1 a request to address 0 is consumed but never written.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  when high, no new grants are issued.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write value.
- req0_ready  out  1  req0 accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write value.
- req1_ready  out  1  req1 accepted this cycle.
- write_ena  out  1  to register file write enable.
- address3  out  ADDR_W  to register file write address.
- write_data  out  DATA_W  to register file write data.
- init_done  out  1  high once the sweep completes.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. Asserting rst at any time, including mid-sweep or mid-transfer, immediately forces reset values.
- Reset values: state=INIT, sweep_cnt=0, rr_ptr=0, write_ena=0, address3=0, write_data=0, init_done=0, req0_ready=0, req1_ready=0.
- States: INIT and RUN.
- INIT sweep:
  - Each rising edge registers write_ena=1, address3=sweep_cnt, write_data=INIT_VALUE, then increments sweep_cnt.
  - The first edge after rst deasserts presents address 0. The sweep covers addresses 0..NUM_REGS-1 on NUM_REGS consecutive cycles.
  - On the edge that registers address NUM_REGS-1, state goes to RUN and init_done is set to 1.
  - Readies are 0 throughout INIT. hold is ignored in INIT.
- RUN, grant (combinational):
  - Both readies are 0 when hold=1.
  - Otherwise, if exactly one valid is high, that requester is granted.
  - If both are high, the requester indexed by rr_ptr is granted.
  - reqN_ready = grant_N. At most one ready is high per cycle.
- RUN, pointer update: on any accepted transfer (valid & ready) by requester i, rr_ptr <= ~i. It is unchanged when there is no transfer.
- RUN, write (registered, 1-cycle latency):
  - On the edge of an accepted transfer, write_ena<=1, address3<=addr, write_data<=data.
  - If ZERO_PROTECT=1 and addr==0, write_ena<=0, while address3/write_data are still updated. The request is still handshaken.
  - With no accepted transfer, write_ena<=0 and address3/write_data hold their previous values.
- Throughput: one write per cycle. A requester holding valid continuously alongside the other gets every second slot.
- Requester obligations: addr/data stable while valid && !ready. The scheduler never drops or duplicates a handshaken request.
- Other rules:
  - hold asserted in the same cycle as valid means no grant; the request is held off.
  - init_done stays 1 until the next reset.

Decomposition:
- Shared package regfile_pkg: ADDR_W, DATA_W, NUM_REGS, the state encoding (INIT, RUN), REG_ZERO=0.
- Sub-module rr_arb2: 2-input round-robin arbiter taking valid[1:0], enable and advance, producing a one-hot grant[1:0] and holding rr_ptr internally.
- The top level holds the FSM, the sweep counter and the write-port output registers.

Test Plan:
- Reset release, no requests -> write_ena=1 for exactly 32 consecutive cycles with address3=0..31 and write_data=0. init_done rises on the edge registering address 31. Readies stay 0 throughout.
- After init, req0 only: addr=5, data=0xDEADBEEF -> req0_ready=1 the same cycle. Next cycle write_ena=1, address3=5, write_data=0xDEADBEEF. Following cycle write_ena=0.
- Both valid continuously (req0 addr=1/data=0x11, req1 addr=2/data=0x22) from rr_ptr=0 -> grants alternate 0,1,0,1 and writes alternate addr 1,2,1,2, one per cycle.
- req1 addr=0, data=0xFFFFFFFF, ZERO_PROTECT=1 -> req1_ready=1, next cycle write_ena=0. With ZERO_PROTECT=0 -> write_ena=1, address3=0.
- hold=1 with both valid for 3 cycles -> no readies, write_ena=0. hold falls -> grant resumes per rr_ptr.
- Assert rst at sweep address 17 -> outputs reset immediately. After release the sweep restarts at address 0 and runs the full 32 cycles. Asserting rst during RUN likewise restarts the sweep.
